if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage.sv | 123 ++++++++++++
 tb/tb_if_fetch_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC selection, IF/ID capture, misaligned-target fault.
// Optional IF_PERF_CNT_EN adds a fetch_count output counting instructions loaded into IF/ID.
module if_fetch_stage #(
  parameter int                     PC_WIDTH_LENGTH   = 32,
  parameter int                     INST_WIDTH_LENGTH = 32,
  parameter logic [PC_WIDTH_LENGTH-1:0]   RESET_PC    = 32'h0000_0000,
  parameter logic [INST_WIDTH_LENGTH-1:0] NOP_INST    = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
  output logic [PC_WIDTH_LENGTH-1:0]   imem_addr,
  input  logic [INST_WIDTH_LENGTH-1:0] imem_inst,
  output logic                         id_valid,
  output logic [PC_WIDTH_LENGTH-1:0]   id_pc,
  output logic [INST_WIDTH_LENGTH-1:0] id_inst,
  output logic                         fetch_fault,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]                  fetch_count,
`endif
  output logic [PC_WIDTH_LENGTH-1:0]   fault_pc
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  typedef struct packed {
    logic                         vld;
    logic [PC_WIDTH_LENGTH-1:0]   pc;
    logic [INST_WIDTH_LENGTH-1:0] inst;
  } ifid_t;

  state_t                       state_q, state_n;
  logic [PC_WIDTH_LENGTH-1:0]   pc_q, pc_n;
  ifid_t                        ifid_q, ifid_n;
  logic                         fault_q, fault_n;
  logic [PC_WIDTH_LENGTH-1:0]   fpc_q, fpc_n;
  logic                         adv;
  logic                         rd_misal;

  assign rd_misal = |redirect_pc[1:0];

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    ifid_n  = ifid_q;
    fault_n = fault_q;
    fpc_n   = fpc_q;
    adv     = 1'b0;
    case (state_q)
      BOOT: state_n = RUN;
      RUN: begin
        if (redirect_valid) begin
          // redirect beats stall: the bubble is written even while stalled
          pc_n        = redirect_pc;
          ifid_n.vld  = 1'b0;
          ifid_n.inst = NOP_INST;
          if (rd_misal) begin
            fault_n = 1'b1;
            fpc_n   = redirect_pc;
            state_n = FAULT;
          end
        end else if (!stall) begin
          adv         = 1'b1;
          ifid_n.vld  = 1'b1;
          ifid_n.pc   = pc_q;
          ifid_n.inst = imem_inst;
          pc_n        = pc_q + PC_WIDTH_LENGTH'(4);
        end
      end
      FAULT: begin
        ifid_n.vld = 1'b0;
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (rd_misal) begin
            fpc_n = redirect_pc;
          end else begin
            fault_n = 1'b0;
            state_n = RUN;
          end
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      ifid_q.vld  <= 1'b0;
      ifid_q.pc   <= '0;
      ifid_q.inst <= NOP_INST;
      fault_q     <= 1'b0;
      fpc_q       <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      ifid_q  <= ifid_n;
      fault_q <= fault_n;
      fpc_q   <= fpc_n;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)      cnt_q <= '0;
    else if (adv) cnt_q <= cnt_q + 32'd1;
  end
  assign fetch_count = cnt_q;
`endif

  // imem_addr is the registered PC, never next-PC: one cycle fetch latency
  assign imem_addr   = pc_q;
  assign id_valid    = ifid_q.vld;
  assign id_pc       = ifid_q.pc;
  assign id_inst     = ifid_q.inst;
  assign fetch_fault = fault_q;
  assign fault_pc    = fpc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed test-plan scenarios then randomized traffic vs a reference model.
module tb_if_fetch_stage;

  logic        gclk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_inst, id_pc, id_inst, fault_pc;
  logic        id_valid, fetch_fault;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 gclk = ~gclk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 32'hDEAD_BEEF;
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_inst = mem(imem_addr);

  if_fetch_stage dut (
    .clk(gclk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .fetch_fault(fetch_fault),
`ifdef IF_PERF_CNT_EN
    .fetch_count(fetch_count),
`endif
    .fault_pc(fault_pc)
  );

  // reference model: mode 0 = just out of reset, 1 = fetching, 2 = parked on bad target
  int          m_mode;
  logic [31:0] m_pc, m_ipc, m_iinst, m_fpc, m_cnt;
  logic        m_iv, m_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic st, input logic rv, input logic [31:0] rpc);
    if (r) begin
      m_mode = 0; m_pc = 32'h0; m_iv = 0; m_ipc = 0; m_iinst = 32'h13;
      m_f = 0; m_fpc = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (rv) begin
        m_pc = rpc; m_iv = 0; m_iinst = 32'h13;
        if (rpc % 4 != 0) begin m_f = 1; m_fpc = rpc; m_mode = 2; end
      end else if (!st) begin
        m_ipc = m_pc; m_iinst = mem(m_pc); m_iv = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
    end else begin
      m_iv = 0;
      if (rv) begin
        m_pc = rpc;
        if (rpc % 4 == 0) begin m_f = 0; m_mode = 1; end
        else m_fpc = rpc;
      end
    end
  endtask

  task automatic step(input logic r, input logic st, input logic rv, input logic [31:0] rpc);
    @(negedge gclk);
    rst = r; stall = st; redirect_valid = rv; redirect_pc = rpc;
    @(posedge gclk);
    model_edge(r, st, rv, rpc);
    #1;
    chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_iv});
    chk("id_pc", id_pc, m_ipc);
    chk("id_inst", id_inst, m_iinst);
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_f});
    chk("fault_pc", fault_pc, m_fpc);
`ifdef IF_PERF_CNT_EN
    chk("fetch_count", fetch_count, m_cnt);
`endif
  endtask

  task automatic idle(); step(1'b0, 1'b0, 1'b0, 32'h0); endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_pc", imem_addr, 32'h0);
    chk("rst_inst", id_inst, 32'h13);
    chk("rst_valid", {31'b0, id_valid}, 32'h0);

    idle();
    chk("boot_valid", {31'b0, id_valid}, 32'h0);
    idle();
    chk("tp_pc0", id_pc, 32'h0);
    chk("tp_inst0", id_inst, 32'h00A0_0093);
    chk("tp_valid0", {31'b0, id_valid}, 32'h1);
    idle();
    chk("tp_pc1", id_pc, 32'h4);
    chk("tp_inst1", id_inst, 32'h0010_0113);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("stall_pc", imem_addr, 32'h8);
      chk("stall_idpc", id_pc, 32'h4);
    end
    idle();
    chk("unstall_idpc", id_pc, 32'h8);

    step(1'b0, 1'b1, 1'b1, 32'h40);
    chk("rdst_pc", imem_addr, 32'h40);
    chk("rdst_valid", {31'b0, id_valid}, 32'h0);
    chk("rdst_inst", id_inst, 32'h13);
    idle();
    chk("rdst_idpc", id_pc, 32'h40);
    chk("rdst_valid2", {31'b0, id_valid}, 32'h1);

    step(1'b0, 1'b0, 1'b1, 32'h42);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, (i % 2) == 0, 1'b0, 32'h0);
      chk("flt_flag", {31'b0, fetch_fault}, 32'h1);
      chk("flt_pc", fault_pc, 32'h42);
      chk("flt_valid", {31'b0, id_valid}, 32'h0);
    end
    step(1'b0, 1'b0, 1'b1, 32'h100);
    chk("flt_clear", {31'b0, fetch_fault}, 32'h0);
    idle();
    chk("flt_idpc", id_pc, 32'h100);
    chk("flt_valid2", {31'b0, id_valid}, 32'h1);

    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    idle();
    chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc", imem_addr, 32'h0);

    step(1'b0, 1'b0, 1'b1, 32'h1C);
    idle();
    chk("mid_pc", imem_addr, 32'h20);
    step(1'b1, 1'b0, 1'b1, 32'h42);
    chk("mid_rst_pc", imem_addr, 32'h0);
    chk("mid_rst_valid", {31'b0, id_valid}, 32'h0);
    chk("mid_rst_inst", id_inst, 32'h13);
    chk("mid_rst_fault", {31'b0, fetch_fault}, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("cnt_rst", fetch_count, 32'h0);
`endif
    idle();
    for (int i = 0; i < 10; i++) idle();
`ifdef IF_PERF_CNT_EN
    chk("cnt_10", fetch_count, 32'd10);
`endif
    chk("adv10_pc", imem_addr, 32'd40);

    for (int i = 0; i < 3000; i++) begin
      logic        r, st, rv;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 99) < 30);
      rv  = ($urandom_range(0, 99) < 12);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8 | (rpc & 32'h7);
      step(r, st, rv, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
